sum_latch_uart_tx: RTL and testbench



---
 rtl/sum_latch_pkg.sv | 18 +
 rtl/sum_latch_uart_tx_core.sv | 63 ++++++
 rtl/sum_latch_uart_tx.sv | 139 +++++++++++++
 tb/tb_sum_latch_uart_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_latch_pkg.sv
// Shared types, constants and helpers for the sum/latch UART transmitter.
package sum_latch_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // ceil((data_w + 1) / 4): digits needed for the DATA_W+1 bit result
  function automatic int hex_digits(input int data_w);
    return (data_w + 4) / 4;
  endfunction

endpackage

// File: rtl/sum_latch_uart_tx_core.sv
// 8N1 serialiser: one byte per start pulse, done pulses the cycle after the stop bit.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic [8:0]       shift_q;
  logic             txd_q;
  logic             active_q;
  logic             done_q;

  // bit_q: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      txd_q    <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (start) begin
          active_q <= 1'b1;
          txd_q    <= 1'b0;
          shift_q  <= {1'b1, data};
          cnt_q    <= '0;
          bit_q    <= '0;
        end
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          txd_q   <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign txd  = txd_q;
  assign busy = active_q;
  assign done = done_q;

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Latches two operands from button strobes, adds or subtracts them and sends the
// result as uppercase hex plus CR LF over UART.
module sum_latch_uart_tx
  import sum_latch_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic              op_sub,
  input  logic [DATA_W-1:0] data_input,
  output logic              uart_txd,
  output logic              uart_tx_busy,
  output logic [DATA_W:0]   result,
  output logic              result_valid
);

  localparam int HEX_DIGITS = hex_digits(DATA_W);
  localparam int RES_W      = DATA_W + 1;
  localparam int PAD_W      = 4 * HEX_DIGITS;
  localparam int IDX_W      = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEX_DIGITS + 1);

  logic [1:0] btn_n;
  logic [1:0] fall;
  assign btn_n = {save_b_n, save_a_n};

  // Chains reset to 1 so releasing reset with a button up never looks like a press
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '1;
        prev_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n[gi]};
        prev_q <= sync_q[SYNC_STAGES-1];
      end
    end
    assign fall[gi] = prev_q & ~sync_q[SYNC_STAGES-1];
  end

  logic pulse_a, pulse_b;
  assign pulse_a = fall[0];
  assign pulse_b = fall[1];

  state_e            state_q;
  logic [DATA_W-1:0] reg_a_q, reg_b_q, reg_a_d, reg_b_d;
  logic [RES_W-1:0]  result_q, alu_res;
  logic              result_valid_q, pending_q;
  logic [IDX_W-1:0]  char_idx_q, sel_idx;
  logic [PAD_W-1:0]  res_pad;
  logic [7:0]        tx_data;
  logic              tx_start, tx_done, core_busy;
  logic              start_msg, frame_done, last_char, advance, finish, launch;

  // The result is captured on the edge that enters LOAD, so it sees same-cycle operand loads
  always_comb begin
    reg_a_d = pulse_a ? data_input : reg_a_q;
    reg_b_d = pulse_b ? data_input : reg_b_q;
    alu_res = op_sub ? ({1'b0, reg_a_d} - {1'b0, reg_b_d})
                     : ({1'b0, reg_a_d} + {1'b0, reg_b_d});
  end

  assign start_msg  = pending_q | pulse_b;
  assign frame_done = (state_q == WAIT) && tx_done;
  assign last_char  = (char_idx_q == LAST_IDX);
  assign advance    = frame_done && !last_char;
  assign finish     = frame_done && last_char;
  assign launch     = ((state_q == IDLE) || finish) && start_msg;

  // LOAD hands char 0 straight to the core and WAIT chains the next char on done,
  // keeping the inter-character gap to a single idle cycle.
  assign tx_start = ((state_q == LOAD) || (state_q == SEND) || advance) && !core_busy;

  always_comb begin
    if (state_q == LOAD)      sel_idx = '0;
    else if (state_q == SEND) sel_idx = char_idx_q;
    else                      sel_idx = char_idx_q + IDX_W'(1);
    res_pad = PAD_W'(result_q);
    tx_data = ASCII_LF;
    if (sel_idx == IDX_W'(HEX_DIGITS)) tx_data = ASCII_CR;
    for (int i = 0; i < HEX_DIGITS; i++) begin
      if (sel_idx == IDX_W'(i)) tx_data = nibble_to_ascii(res_pad[(HEX_DIGITS-1-i)*4 +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      reg_a_q        <= '0;
      reg_b_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      pending_q      <= 1'b0;
      char_idx_q     <= '0;
    end else begin
      reg_a_q        <= reg_a_d;
      reg_b_q        <= reg_b_d;
      result_valid_q <= launch;
      pending_q      <= launch ? 1'b0 : start_msg;
      if (launch) result_q <= alu_res;
      case (state_q)
        IDLE: if (launch) state_q <= LOAD;
        LOAD: begin
          char_idx_q <= '0;
          state_q    <= WAIT;
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (finish)       state_q <= launch ? LOAD : IDLE;
          else if (advance) char_idx_q <= char_idx_q + IDX_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (tx_data),
    .txd   (uart_txd),
    .busy  (core_busy),
    .done  (tx_done)
  );

  // Drops in the done cycle of the final LF unless another message follows immediately
  assign uart_tx_busy = (state_q != IDLE) && !(finish && !start_msg);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Scoreboard bench: stimulus queues expected results/bytes/busy lengths, monitors pop and compare.
module tb_sum_latch_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       save_a_n = 1'b1;
  logic       save_b_n = 1'b1;
  logic       op_sub = 1'b0;
  logic [3:0] data_input = 4'h0;
  logic       uart_txd, uart_tx_busy, result_valid;
  logic [4:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int gen = 0;

  logic [4:0] exp_res[$];
  logic [7:0] exp_bytes[$];
  int         exp_lo[$];
  int         exp_hi[$];

  sum_latch_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .save_a_n     (save_a_n),
    .save_b_n     (save_b_n),
    .op_sub       (op_sub),
    .data_input   (data_input),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic push_msg(input logic [4:0] res, input logic [7:0] c0, input logic [7:0] c1);
    exp_res.push_back(res);
    exp_bytes.push_back(c0);
    exp_bytes.push_back(c1);
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
  endtask

  task automatic push_busy(input int lo, input int hi);
    exp_lo.push_back(lo);
    exp_hi.push_back(hi);
  endtask

  task automatic strobe(input bit do_a, input bit do_b, input logic [3:0] d);
    @(posedge clk); #1 data_input = d;
    repeat (2) @(posedge clk);
    #1;
    if (do_a) save_a_n = 1'b0;
    if (do_b) save_b_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 save_a_n = 1'b1; save_b_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int k = 0;
    while (uart_tx_busy !== lvl && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq(name, (uart_tx_busy === lvl) ? 1 : 0, 1);
  endtask

  // Result monitor
  initial begin : res_mon
    forever begin
      @(negedge clk);
      if (!reset && result_valid) begin
        if (exp_res.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL result_unexpected: got 0x%0h, expected no result_valid", result);
        end else begin
          check_eq("result", result, exp_res.pop_front());
        end
      end
    end
  end

  // UART decoder, mid-bit sampling on the falling clock edge
  initial begin : uart_mon
    logic [7:0] b;
    logic       s0, s9;
    int         g, k;
    bit         have;
    have = 1'b0;
    forever begin
      if (!have) begin
        @(negedge clk);
        if (reset || uart_txd !== 1'b0) continue;
      end
      have = 1'b0;
      g = gen;
      repeat (2) @(negedge clk);
      s0 = uart_txd;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (4) @(negedge clk);
      s9 = uart_txd;
      if (g != gen) continue;
      check_eq("start_bit", s0, 0);
      check_eq("stop_bit", s9, 1);
      if (exp_bytes.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL uart_unexpected: got byte 0x%0h, expected none", b);
      end else begin
        check_eq("uart_byte", b, exp_bytes.pop_front());
      end
      if (uart_tx_busy) begin
        k = 0;
        while (uart_txd && uart_tx_busy && k < 20) begin
          @(negedge clk);
          k++;
        end
        if (!uart_txd) begin
          check_range("char_gap", k, 1, 4);
          have = 1'b1;
        end
      end
    end
  end

  // Busy-length monitor; runs interrupted by reset are ignored
  initial begin : busy_mon
    int run;
    bit rsr;
    run = 0;
    rsr = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_busy === 1'b1) begin
        run++;
        if (reset) rsr = 1'b1;
      end else begin
        if (run > 0 && !rsr) begin
          if (exp_lo.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL busy_unexpected: got run of %0d, expected none", run);
          end else begin
            check_range("busy_len", run, exp_lo.pop_front(), exp_hi.pop_front());
          end
        end
        run = 0;
        rsr = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] va[2];
    logic [3:0] vb[2];
    logic       vs[2];
    logic [4:0] vr[2];
    logic [7:0] vc0[2];
    logic [7:0] vc1[2];
    int bad;
    va[0] = 4'd9; vb[0] = 4'd8; vs[0] = 1'b0; vr[0] = 5'h11; vc0[0] = 8'h31; vc1[0] = 8'h31;
    va[1] = 4'd3; vb[1] = 4'd5; vs[1] = 1'b1; vr[1] = 5'h1E; vc0[1] = 8'h31; vc1[1] = 8'h45;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("reset_txd", uart_txd, 1);
    check_eq("reset_busy", uart_tx_busy, 0);
    check_eq("reset_result", result, 0);
    check_eq("reset_valid", result_valid, 0);
    @(posedge clk); #1 reset = 1'b0;

    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0 || result !== 5'd0 || result_valid !== 1'b0) bad++;
    end
    check_eq("idle_quiet_cycles", bad, 0);

    for (int i = 0; i < 2; i++) begin
      strobe(1'b1, 1'b0, va[i]);
      op_sub = vs[i];
      push_msg(vr[i], vc0[i], vc1[i]);
      push_busy(160, 164);
      strobe(1'b0, 1'b1, vb[i]);
      wait_busy(1'b1, 50, "vec_busy_rise");
      wait_busy(1'b0, 400, "vec_busy_fall");
      op_sub = 1'b0;
      repeat (10) @(posedge clk);
    end

    // 15+15, then B=1 mid-message, then B=2 and B=3 coalescing into one message
    strobe(1'b1, 1'b0, 4'd15);
    push_msg(5'h1E, 8'h31, 8'h45);
    push_msg(5'h10, 8'h31, 8'h30);
    push_msg(5'h12, 8'h31, 8'h32);
    push_busy(480, 495);
    strobe(1'b0, 1'b1, 4'd15);
    wait_busy(1'b1, 50, "coal_busy_rise");
    repeat (40) @(posedge clk);
    strobe(1'b0, 1'b1, 4'd1);
    repeat (150) @(posedge clk);
    strobe(1'b0, 1'b1, 4'd2);
    strobe(1'b0, 1'b1, 4'd3);
    wait_busy(1'b0, 1500, "coal_busy_fall");
    repeat (10) @(posedge clk);

    push_msg(5'h0E, 8'h30, 8'h45);
    push_busy(160, 164);
    strobe(1'b1, 1'b1, 4'd7);
    wait_busy(1'b1, 50, "both_busy_rise");
    wait_busy(1'b0, 400, "both_busy_fall");
    repeat (10) @(posedge clk);

    // Reset during the data bits of the second character
    push_msg(5'h09, 8'h30, 8'h39);
    strobe(1'b0, 1'b1, 4'd2);
    repeat (48) @(posedge clk);
    #1 reset = 1'b1;
    gen++;
    @(posedge clk);
    @(negedge clk);
    exp_bytes.delete();
    check_eq("midreset_txd", uart_txd, 1);
    check_eq("midreset_busy", uart_tx_busy, 0);
    check_eq("midreset_result", result, 0);
    @(posedge clk); #1 reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) bad++;
    end
    check_eq("post_reset_quiet_cycles", bad, 0);

    // reg_a was cleared by reset, so 0 + 12
    push_msg(5'h0C, 8'h30, 8'h43);
    push_busy(160, 164);
    strobe(1'b0, 1'b1, 4'd12);
    wait_busy(1'b1, 50, "fresh_busy_rise");
    wait_busy(1'b0, 400, "fresh_busy_fall");
    repeat (20) @(posedge clk);

    check_eq("bytes_left", exp_bytes.size(), 0);
    check_eq("results_left", exp_res.size(), 0);
    check_eq("busy_runs_left", exp_lo.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
